// File: rtl/rgb_seq_pkg.sv
// rgb_seq_pkg
// Shared types and constants for the RGB pattern sequencer.
//   state_t  : sequencer FSM states
//   entry_t  : one pattern entry (colour code + dwell in ticks) at default width
//   CODE_W   : width of a colour code, {R[1:0],G[1:0],B[1:0]} as on SW
package rgb_seq_pkg;

  localparam int CODE_W           = 6;
  localparam int TICK_DIV_DEFAULT = 100000;
  localparam int DWELL_W_DEFAULT  = 8;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  typedef struct packed {
    logic [CODE_W-1:0]          code;
    logic [DWELL_W_DEFAULT-1:0] dwell;
  } entry_t;

endpackage

// File: rtl/rgb_tick_gen.sv
// rgb_tick_gen
// Dwell-tick prescaler. Counts 0..TICK_DIV-1 while enabled and flags the
// cycle in which the count sits at TICK_DIV-1; the count then wraps to 0.
// Ports:
//   clock  in  system clock
//   reset  in  asynchronous reset, active-low
//   clear  in  hold the prescaler at 0 (wins over enable)
//   enable in  count
//   tick   out high for the single cycle where the count is TICK_DIV-1
module rgb_tick_gen
  import rgb_seq_pkg::*;
#(
  parameter int TICK_DIV = TICK_DIV_DEFAULT
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic tick
);

  localparam int CNT_W = $clog2(TICK_DIV);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else if (clear) begin
      cnt_q <= '0;
    end else if (enable) begin
      cnt_q <= (cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;
    end
  end

  assign tick = enable && !clear && (cnt_q == CNT_LAST);

endmodule

// File: rtl/rgb_pattern_sequencer.sv
// rgb_pattern_sequencer
// Plays a programmable list of colour codes into the RGB PWM controller's
// 6-bit switch-code input. Each entry is shown for max(dwell,1) ticks of
// TICK_DIV cycles; playback runs once or loops over entries 0..last_idx.
//
//   state | meaning
//   IDLE  | output dark (code_out=0), waiting for start
//   RUN   | showing entry idx, counting down its dwell
//
// Ports:
//   clock, reset       system clock, asynchronous active-low reset
//   wr_en/wr_addr/     pattern memory write port (any state; a load in the
//   wr_code/wr_dwell   same cycle as a write to that entry sees old data)
//   start, stop        playback control pulses (stop wins)
//   loop, last_idx     playback mode and final entry, captured at start
//   code_out           colour code to the PWM controller
//   busy               high while playing
//   done               one-cycle pulse at the end of a one-shot play
//   idx                entry currently displayed
module rgb_pattern_sequencer
  import rgb_seq_pkg::*;
#(
  parameter int DEPTH    = 8,
  parameter int TICK_DIV = TICK_DIV_DEFAULT,
  parameter int DWELL_W  = 8
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     wr_en,
  input  logic [$clog2(DEPTH)-1:0] wr_addr,
  input  logic [CODE_W-1:0]        wr_code,
  input  logic [DWELL_W-1:0]       wr_dwell,
  input  logic                     start,
  input  logic                     stop,
  input  logic                     loop,
  input  logic [$clog2(DEPTH)-1:0] last_idx,
  output logic [CODE_W-1:0]        code_out,
  output logic                     busy,
  output logic                     done,
  output logic [$clog2(DEPTH)-1:0] idx
);

  localparam int AW = $clog2(DEPTH);

  logic [CODE_W-1:0]  mem_code  [DEPTH];
  logic [DWELL_W-1:0] mem_dwell [DEPTH];

  state_t             state_q, state_d;
  logic [DWELL_W-1:0] dwell_q, dwell_d;
  logic               loop_q, loop_d;
  logic [AW-1:0]      last_q, last_d;
  logic [CODE_W-1:0]  code_d;
  logic               busy_d, done_d;
  logic [AW-1:0]      idx_d;
  logic [AW-1:0]      idx_next;
  logic               tick;

  // A zero dwell still shows the entry for one tick.
  function automatic logic [DWELL_W-1:0] dwell_init(input logic [DWELL_W-1:0] d);
    return (d == '0) ? DWELL_W'(1) : d;
  endfunction

  rgb_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .clock  (clock),
    .reset  (reset),
    .clear  (state_q == IDLE),
    .enable (state_q == RUN),
    .tick   (tick)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_code[i]  <= '0;
        mem_dwell[i] <= '0;
      end
    end else if (wr_en) begin
      mem_code[wr_addr]  <= wr_code;
      mem_dwell[wr_addr] <= wr_dwell;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      dwell_q  <= '0;
      loop_q   <= 1'b0;
      last_q   <= '0;
      code_out <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      idx      <= '0;
    end else begin
      state_q  <= state_d;
      dwell_q  <= dwell_d;
      loop_q   <= loop_d;
      last_q   <= last_d;
      code_out <= code_d;
      busy     <= busy_d;
      done     <= done_d;
      idx      <= idx_d;
    end
  end

  assign idx_next = idx + 1'b1;

  always_comb begin
    state_d = state_q;
    dwell_d = dwell_q;
    loop_d  = loop_q;
    last_d  = last_q;
    code_d  = code_out;
    busy_d  = busy;
    done_d  = 1'b0;
    idx_d   = idx;

    unique case (state_q)
      IDLE: begin
        code_d = '0;
        busy_d = 1'b0;
        idx_d  = '0;
        if (start && !stop) begin
          state_d = RUN;
          loop_d  = loop;
          last_d  = last_idx;
          busy_d  = 1'b1;
          code_d  = mem_code[0];
          dwell_d = dwell_init(mem_dwell[0]);
        end
      end

      RUN: begin
        if (stop) begin
          state_d = IDLE;
          code_d  = '0;
          busy_d  = 1'b0;
          idx_d   = '0;
        end else if (tick) begin
          if (dwell_q > DWELL_W'(1)) begin
            dwell_d = dwell_q - 1'b1;
          end else if (idx < last_q) begin
            idx_d   = idx_next;
            code_d  = mem_code[idx_next];
            dwell_d = dwell_init(mem_dwell[idx_next]);
          end else if (loop_q) begin
            idx_d   = '0;
            code_d  = mem_code[0];
            dwell_d = dwell_init(mem_dwell[0]);
          end else begin
            state_d = IDLE;
            code_d  = '0;
            busy_d  = 1'b0;
            idx_d   = '0;
            done_d  = 1'b1;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

endmodule
